// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver family: state codes,
// parity mode codes and a constant-safe ceil(log2) helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Bits needed to hold values 0..n-1; never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit over a DBITS-wide word; odd=1 selects odd parity.
module uart_parity_gen #(
  parameter int DBITS = 8
) (
  input  logic [DBITS-1:0] data,
  input  logic             odd,
  output logic             parity
);

  assign parity = (^data) ^ odd;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (DBITS data, optional odd/even parity, SB_TICKS stop).
// Define UART_TX_BREAK_EN to add the send_break input for line-break generation.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBITS    = 8,
  parameter int OS_TICKS = 16,
  parameter int SB_TICKS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  input  logic             tx_start,
  input  logic [DBITS-1:0] din,
  input  logic [1:0]       parity_mode,
`ifdef UART_TX_BREAK_EN
  input  logic             send_break,
`endif
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int TW = clog2((OS_TICKS > SB_TICKS) ? OS_TICKS : SB_TICKS);
  localparam int BW = clog2(DBITS);
  localparam logic [TW-1:0] OS_LAST  = TW'(OS_TICKS - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBITS - 1);

  uart_state_t      state;
  logic [TW-1:0]    tick_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [DBITS-1:0] shift_q;
  logic [DBITS-1:0] data_q;
  logic [1:0]       mode_q;
  logic             par_en;
  logic             par_bit;

`ifdef UART_TX_BREAK_EN
  logic brk_hold;
  logic brk_stop;
`endif

  // Parity comes from the word captured at acceptance, never the shifter.
  uart_parity_gen #(.DBITS(DBITS)) u_parity (
    .data   (data_q),
    .odd    (mode_q == PAR_ODD),
    .parity (par_bit)
  );

  assign par_en = (mode_q == PAR_ODD) || (mode_q == PAR_EVEN);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      mode_q   <= PAR_NONE;
`ifdef UART_TX_BREAK_EN
      brk_hold <= 1'b0;
      brk_stop <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
`ifdef UART_TX_BREAK_EN
          if (send_break) begin
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            brk_hold <= 1'b1;
          end else if (brk_hold) begin
            brk_hold <= 1'b0;
            brk_stop <= 1'b1;
            tick_cnt <= '0;
            state    <= STOP;
          end else
`endif
          if (tx_start) begin
            data_q   <= din;
            shift_q  <= din;
            mode_q   <= parity_mode;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
`ifdef UART_TX_BREAK_EN
            brk_stop <= 1'b0;
`endif
          end
        end

        START: begin
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= DATA;
              tx       <= shift_q[0];
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              shift_q  <= shift_q >> 1;
              if (bit_cnt == BIT_LAST) begin
                if (par_en) begin
                  state <= PARITY;
                  tx    <= par_bit;
                end else begin
                  state <= STOP;
                  tx    <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx      <= shift_q[1];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              state    <= STOP;
              tx       <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (s_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              tx_busy  <= 1'b0;
`ifdef UART_TX_BREAK_EN
              tx_done  <= ~brk_stop;
              brk_stop <= 1'b0;
`else
              tx_done  <= 1'b1;
`endif
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          tx_busy  <= 1'b0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected line segments are queued when a
// frame is started and popped while the serial line is sampled each cycle.
module tb_uart_tx_cfg;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       tx_start_a, tx_start_b;
  logic [7:0] din_a;
  logic [6:0] din_b;
  logic [1:0] pm;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;
`ifdef UART_TX_BREAK_EN
  logic       send_break;
`endif

  uart_tx_cfg #(.DBITS(8), .OS_TICKS(16), .SB_TICKS(16)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .tx_start    (tx_start_a),
    .din         (din_a),
    .parity_mode (pm),
`ifdef UART_TX_BREAK_EN
    .send_break  (send_break),
`endif
    .tx          (tx_a),
    .tx_busy     (busy_a),
    .tx_done     (done_a)
  );

  uart_tx_cfg #(.DBITS(7), .OS_TICKS(16), .SB_TICKS(32)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .tx_start    (tx_start_b),
    .din         (din_b),
    .parity_mode (pm),
`ifdef UART_TX_BREAK_EN
    .send_break  (1'b0),
`endif
    .tx          (tx_b),
    .tx_busy     (busy_b),
    .tx_done     (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic level;
    int   cycles;
  } seg_t;

  seg_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected line shape with s_tick every clk: start, LSB-first data, optional parity, stop.
  function automatic int push_frame(input logic [8:0] data, input int nbits,
                                    input logic [1:0] mode, input int stop_len);
    int ones;
    int n;
    seg_t s;
    ones = 0;
    n = 0;
    s.level = 1'b0; s.cycles = 16; sb_q.push_back(s); n++;
    for (int i = 0; i < nbits; i++) begin
      s.level = data[i]; s.cycles = 16; sb_q.push_back(s); n++;
      if (data[i]) ones++;
    end
    if (mode == 2'b01 || mode == 2'b10) begin
      // Even: bit makes total ones even. Odd: makes it odd.
      s.level = (mode == 2'b10) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      s.cycles = 16; sb_q.push_back(s); n++;
    end
    s.level = 1'b1; s.cycles = stop_len; sb_q.push_back(s); n++;
    return n;
  endfunction

  task automatic start_a(input logic [7:0] d, input logic [1:0] m, output int nseg);
    din_a = d; pm = m; tx_start_a = 1'b1;
    nseg = push_frame({1'b0, d}, 8, m, 16);
    @(negedge clk);
    tx_start_a = 1'b0;
  endtask

  // Samples one frame from the first cycle after acceptance. Optionally pulses a
  // stray tx_start mid-frame and/or starts a chained frame on the tx_done cycle.
  task automatic check_frame(input bit sel, input int nseg, input string name,
                             input int inject_at, input bit chain,
                             input logic [7:0] chain_d, input logic [1:0] chain_m,
                             output int chain_nseg);
    seg_t s;
    int   cyc;
    int   bad_cyc;
    logic t, b, d;
    cyc = 0;
    chain_nseg = 0;
    for (int k = 0; k < nseg; k++) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s scoreboard empty at segment %0d", name, k);
        break;
      end
      s = sb_q.pop_front();
      bad_cyc = -1;
      t = 1'b0; b = 1'b0; d = 1'b0;
      for (int c = 0; c < s.cycles; c++) begin
        if ((sel ? tx_b : tx_a) !== s.level || (sel ? busy_b : busy_a) !== 1'b1 ||
            (sel ? done_b : done_a) !== 1'b0) begin
          if (bad_cyc < 0) begin
            bad_cyc = c;
            t = sel ? tx_b : tx_a; b = sel ? busy_b : busy_a; d = sel ? done_b : done_a;
          end
        end
        if (cyc == inject_at) begin
          tx_start_a = 1'b1; din_a = 8'hAA; pm = 2'b10;
        end else if (cyc == inject_at + 1) begin
          tx_start_a = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
      n_cmp++;
      if (bad_cyc >= 0) begin
        n_bad++;
        $display("FAIL %s seg%0d cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                 name, k, bad_cyc, t, b, d, s.level);
      end
    end
    // Frame end: one-cycle done pulse, busy cleared, line idle.
    n_cmp++;
    if ((sel ? done_b : done_a) !== 1'b1 || (sel ? busy_b : busy_a) !== 1'b0 ||
        (sel ? tx_b : tx_a) !== 1'b1) begin
      n_bad++;
      $display("FAIL %s end: done=%b busy=%b tx=%b, required done=1 busy=0 tx=1 after %0d cycles",
               name, sel ? done_b : done_a, sel ? busy_b : busy_a, sel ? tx_b : tx_a, cyc);
    end
    if (chain) begin
      din_a = chain_d; pm = chain_m; tx_start_a = 1'b1;
      chain_nseg = push_frame({1'b0, chain_d}, 8, chain_m, 16);
      @(negedge clk);
      tx_start_a = 1'b0;
    end else begin
      @(negedge clk);
      n_cmp++;
      if ((sel ? done_b : done_a) !== 1'b0) begin
        n_bad++;
        $display("FAIL %s done_width: done=%b, required 0 one cycle after pulse", name,
                 sel ? done_b : done_a);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_a: tx=%b busy=%b done=%b, required 1 0 0", tx_a, busy_a, done_a);
    end
    n_cmp++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b: tx=%b busy=%b done=%b, required 1 0 0", tx_b, busy_b, done_b);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    int n, dummy;
    start_a(8'h55, 2'b00, n);
    check_frame(1'b0, n, "8n1_55", -1, 1'b0, 8'h00, 2'b00, dummy);
  endtask

  task automatic test_parity();
    int n, dummy;
    start_a(8'h07, 2'b01, n);
    check_frame(1'b0, n, "odd_07", -1, 1'b0, 8'h00, 2'b00, dummy);
    start_a(8'h07, 2'b10, n);
    check_frame(1'b0, n, "even_07", -1, 1'b0, 8'h00, 2'b00, dummy);
    start_a(8'hC3, 2'b11, n);
    check_frame(1'b0, n, "mode11_none", -1, 1'b0, 8'h00, 2'b00, dummy);
    start_a(8'hD2, 2'b01, n);
    check_frame(1'b0, n, "odd_D2", -1, 1'b0, 8'h00, 2'b00, dummy);
  endtask

  task automatic test_dbits7();
    int n, dummy;
    din_b = 7'h7F; pm = 2'b00; tx_start_b = 1'b1;
    n = push_frame({2'b00, 7'h7F}, 7, 2'b00, 32);
    @(negedge clk);
    tx_start_b = 1'b0;
    check_frame(1'b1, n, "d7_7F_sb32", -1, 1'b0, 8'h00, 2'b00, dummy);
  endtask

  task automatic test_back_to_back();
    int n, n2, dummy;
    start_a(8'h55, 2'b00, n);
    check_frame(1'b0, n, "b2b_first", 40, 1'b1, 8'h3C, 2'b10, n2);
    check_frame(1'b0, n2, "b2b_second", -1, 1'b0, 8'h00, 2'b00, dummy);
  endtask

  task automatic test_reset_mid_frame();
    int n, dummy, bad;
    din_a = 8'h55; pm = 2'b00; tx_start_a = 1'b1;
    @(negedge clk);
    tx_start_a = 1'b0;
    repeat (69) @(negedge clk);  // inside data bit 3
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_pre: busy=%b, required 1 before reset", busy_a);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async: tx=%b busy=%b done=%b, required 1 0 0", tx_a, busy_a, done_a);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL rst_mid_idle: %0d bad idle cycles, required 0", bad);
    end
    start_a(8'h01, 2'b00, n);
    check_frame(1'b0, n, "rst_mid_clean_01", -1, 1'b0, 8'h00, 2'b00, dummy);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int bad;
    send_break = 1'b1; tx_start_a = 1'b1; din_a = 8'h00; pm = 2'b00;
    @(negedge clk);
    tx_start_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_a !== 1'b0 || busy_a !== 1'b1) bad++;
      tx_start_a = (i == 50);
      if (i == 99) send_break = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL break_hold: %0d cycles not tx=0 busy=1, required 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (tx_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL break_stop: %0d cycles not tx=1 busy=1 done=0, required 0", bad);
    end
    bad = 0;
    repeat (10) begin
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL break_release: %0d cycles not idle without done, required 0", bad);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; s_tick = 1'b1;
    tx_start_a = 1'b0; tx_start_b = 1'b0;
    din_a = '0; din_b = '0; pm = 2'b00;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity();
    test_dbits7();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    if (sb_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_leftover: %0d segments, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised, runtime-configurable UART transmitter; next generation of the PS/2-mouse project's 8N1 transmitter.
- Serialises a DBITS-wide word LSB-first with optional odd/even parity and a configurable stop-bit length, paced by an external oversampling tick from the shared baud generator.
- Adds a busy flag and a latched per-frame parity mode.
- Feeds the host-side serial link that reports mouse packets.

Parameters:
- DBITS, 8, data bits per frame; legal range 5..9.
- OS_TICKS, 16, s_tick pulses per start/data/parity bit; legal range 8..32.
- SB_TICKS, 16, s_tick pulses in the stop period (16 = 1, 24 = 1.5, 32 = 2 stop bits at OS_TICKS = 16); legal range 1..64.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_tick  in  1  oversample enable, one clk cycle wide
- tx_start  in  1  start request; accepted only while idle
- din  in  DBITS  data word
- parity_mode  in  2  00 none, 01 odd, 10 even, 11 none; sampled on acceptance
- tx  out  1  serial line, idle high
- tx_busy  out  1  high from acceptance until the frame completes
- tx_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (asynchronous, active-high): tx=1, tx_busy=0, tx_done=0, state IDLE, counters and shift register cleared. Reset mid-frame aborts the frame; tx returns high immediately.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - On tx_start, latch din and parity_mode, clear tick and bit counters, go to START, set tx_busy.
  - tx goes low on the clk edge after acceptance; s_tick is not required for acceptance.
- START: tx=0. After OS_TICKS s_ticks, go to DATA with bit counter 0.
- DATA:
  - tx = shift[0].
  - Every OS_TICKS s_ticks, shift right; when bit counter = DBITS-1, go to PARITY if latched mode is 01 or 10, else STOP.
- PARITY:
  - tx = XOR of latched data (even), or its inverse (odd).
  - Parity is computed from the word latched at acceptance, not the shifted register.
  - Lasts OS_TICKS s_ticks, then STOP.
- STOP:
  - tx=1 for SB_TICKS s_ticks.
  - On the final tick, go to IDLE, clear tx_busy, and pulse tx_done high on the same edge for exactly one clk cycle.
- Tick counter: width clog2(max(OS_TICKS, SB_TICKS)); counts only on s_tick; reset to 0 on every state change.
- tx_start while tx_busy=1: ignored; din and parity_mode changes mid-frame have no effect.
- tx_start in the cycle tx_done is high: state is already IDLE, so it is accepted. Back-to-back frames have zero idle gap beyond the stop period.
- Frame length in s_ticks: OS_TICKS*(1+DBITS+P) + SB_TICKS, where P=1 if parity is enabled.
- s_tick asserted on consecutive clk cycles is legal; each assertion counts.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined:
  - Adds input send_break (1 bit).
  - send_break high in IDLE forces tx=0 and tx_busy=1 and blocks tx_start.
  - On deassertion, tx=1 next cycle, then an SB_TICKS stop period runs before tx_busy clears; no tx_done pulse for a break.
  - send_break asserted mid-frame is deferred until the frame's tx_done.
- When undefined: no port, no logic; behaviour exactly as above.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE..STOP, 3 bits);
  - parity mode codes PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10;
  - clog2 function.
- One natural sub-module: uart_parity_gen (combinational XOR reduce over DBITS, with odd/even select), reused later by the receiver.

Test Plan:
- 8N1, din=8'h55, parity_mode=00, s_tick every clk: tx low 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high 16; tx_done pulses once at cycle 160 after acceptance; tx_busy high throughout.
- din=8'h07, parity_mode=01: parity bit = 0; repeat with parity_mode=10: parity bit = 1; frame length 176 ticks.
- DBITS=7, SB_TICKS=32, din=7'h7F, no parity: 7 data bits of 1, stop held 32 ticks, total 160 ticks.
- tx_start pulsed with din=8'hAA mid-frame of 8'h55: ignored, serial output is 8'h55 only. tx_start asserted on the tx_done cycle: second frame's start bit begins the next clk.
- Reset asserted during DATA bit 3: tx=1, tx_busy=0 immediately, no tx_done. Next tx_start with 8'h01 produces a clean frame.
- UART_TX_BREAK_EN: send_break held 100 cycles gives tx=0 for 100 cycles and tx_start ignored; after release, tx=1 and busy clears after 16 ticks with no tx_done pulse.
